// File: rtl/prf_pkg.sv
// Shared definitions for the physical register file: default sizing and the
// tag/data types used by rename, dispatch and the functional units.
package prf_pkg;

   localparam int unsigned NUM_PREGS = 128;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TAG_W     = $clog2(NUM_PREGS);

   typedef logic [TAG_W-1:0]  ptag_t;
   typedef logic [DATA_W-1:0] pdata_t;

endpackage : prf_pkg

// File: rtl/prf_bypass_mux.sv
// One read port of the physical register file: returns the stored value and
// ready bit for a tag, overridden by a same-cycle writeback to that tag.
//   tag       : physical register being read
//   st_data   : stored value of that register
//   st_ready  : stored ready bit of that register
//   wb_valid  : writeback strobes, one per writeback port
//   wb_tag    : writeback destinations, packed port 0 in the low bits
//   wb_data   : writeback values, packed port 0 in the low bits
//   rd_data   : value seen by the consumer (combinational)
//   rd_ready  : value available (combinational)
module prf_bypass_mux #(
   parameter int unsigned DATA_W = prf_pkg::DATA_W,
   parameter int unsigned TAG_W  = prf_pkg::TAG_W,
   parameter int unsigned NUM_WB = 2
) (
   input  logic [TAG_W-1:0]         tag,
   input  logic [DATA_W-1:0]        st_data,
   input  logic                     st_ready,
   input  logic [NUM_WB-1:0]        wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
   input  logic [NUM_WB*DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_ready
);

   // Ascending scan so the highest matching writeback port is the one left
   // standing; p0 overrides everything last.
   always_comb begin
      rd_data  = st_data;
      rd_ready = st_ready;
      for (int i = 0; i < NUM_WB; i++) begin
         if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == tag)) begin
            rd_data  = wb_data[i*DATA_W +: DATA_W];
            rd_ready = 1'b1;
         end
      end
      if (tag == '0) begin
         rd_data  = '0;
         rd_ready = 1'b1;
      end
   end

endmodule : prf_bypass_mux

// File: rtl/phys_regfile.sv
// Physical register file with per-register ready scoreboard, NUM_RD bypassed
// read ports, NUM_WB writeback ports and NUM_ALLOC ready-clear ports.
// NUM_PREGS must be a power of two and at least 32; p0 is hardwired zero.
//   clk, reset   : clock, asynchronous active-high reset
//   rd_tag       : read tags, packed port 0 in the low bits
//   rd_data      : read values (combinational)
//   rd_ready     : read value available (combinational)
//   wb_valid     : writeback strobes
//   wb_tag       : writeback destinations
//   wb_data      : writeback values
//   alloc_valid  : allocation strobes from rename
//   alloc_tag    : newly allocated destination tags
//   wb_conflict  : sticky flag, two valid writebacks hit the same non-zero tag
module phys_regfile #(
   parameter  int unsigned NUM_PREGS = prf_pkg::NUM_PREGS,
   parameter  int unsigned DATA_W    = prf_pkg::DATA_W,
   parameter  int unsigned NUM_RD    = 4,
   parameter  int unsigned NUM_WB    = 2,
   parameter  int unsigned NUM_ALLOC = 2,
   localparam int unsigned TAG_W     = $clog2(NUM_PREGS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_RD*TAG_W-1:0]     rd_tag,
   output logic [NUM_RD*DATA_W-1:0]    rd_data,
   output logic [NUM_RD-1:0]           rd_ready,
   input  logic [NUM_WB-1:0]           wb_valid,
   input  logic [NUM_WB*TAG_W-1:0]     wb_tag,
   input  logic [NUM_WB*DATA_W-1:0]    wb_data,
   input  logic [NUM_ALLOC-1:0]        alloc_valid,
   input  logic [NUM_ALLOC*TAG_W-1:0]  alloc_tag,
   output logic                        wb_conflict
);

   logic [DATA_W-1:0]    mem [NUM_PREGS];
   logic [NUM_PREGS-1:0] ready_vec;
   logic [TAG_W-1:0]     wb_tag_a    [NUM_WB];
   logic [DATA_W-1:0]    wb_data_a   [NUM_WB];
   logic [TAG_W-1:0]     alloc_tag_a [NUM_ALLOC];
   logic                 conflict_c;

   // Unpack the flat port buses for readability below.
   for (genvar i = 0; i < NUM_WB; i++) begin : g_wb_unpack
      assign wb_tag_a[i]  = wb_tag[i*TAG_W +: TAG_W];
      assign wb_data_a[i] = wb_data[i*DATA_W +: DATA_W];
   end

   for (genvar j = 0; j < NUM_ALLOC; j++) begin : g_alloc_unpack
      assign alloc_tag_a[j] = alloc_tag[j*TAG_W +: TAG_W];
   end

   // Per-register storage and ready bit.
   for (genvar r = 0; r < NUM_PREGS; r++) begin : g_reg
      if (r == 0) begin : g_zero
         assign mem[r]       = '0;
         assign ready_vec[r] = 1'b1;
      end else begin : g_live
         logic              we_c;
         logic [DATA_W-1:0] wd_c;
         logic              alloc_hit_c;
         logic [DATA_W-1:0] data_q;
         logic              ready_q;

         // Highest-index writeback wins; any alloc hit wins over writeback
         // for the ready bit because the tag has been reissued.
         always_comb begin
            we_c        = 1'b0;
            wd_c        = '0;
            alloc_hit_c = 1'b0;
            for (int i = 0; i < NUM_WB; i++) begin
               if (wb_valid[i] && (wb_tag_a[i] == TAG_W'(r))) begin
                  we_c = 1'b1;
                  wd_c = wb_data_a[i];
               end
            end
            for (int j = 0; j < NUM_ALLOC; j++) begin
               if (alloc_valid[j] && (alloc_tag_a[j] == TAG_W'(r))) begin
                  alloc_hit_c = 1'b1;
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_q  <= '0;
               ready_q <= 1'b1;
            end else begin
               if (we_c) begin
                  data_q <= wd_c;
               end
               if (alloc_hit_c) begin
                  ready_q <= 1'b0;
               end else if (we_c) begin
                  ready_q <= 1'b1;
               end
            end
         end

         assign mem[r]       = data_q;
         assign ready_vec[r] = ready_q;
      end
   end

   // Pairwise same-tag detection across writeback ports; p0 is exempt.
   always_comb begin
      conflict_c = 1'b0;
      for (int i = 0; i < NUM_WB; i++) begin
         for (int j = i + 1; j < NUM_WB; j++) begin
            if (wb_valid[i] && wb_valid[j] &&
                (wb_tag_a[i] == wb_tag_a[j]) && (wb_tag_a[i] != '0)) begin
               conflict_c = 1'b1;
            end
         end
      end
   end

   // Sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_conflict <= 1'b0;
      end else begin
         wb_conflict <= wb_conflict | conflict_c;
      end
   end

   // Read ports, each with its own writeback bypass.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [TAG_W-1:0] tag;

      assign tag = rd_tag[k*TAG_W +: TAG_W];

      prf_bypass_mux #(
         .DATA_W (DATA_W),
         .TAG_W  (TAG_W),
         .NUM_WB (NUM_WB)
      ) u_mux (
         .tag      (tag),
         .st_data  (mem[tag]),
         .st_ready (ready_vec[tag]),
         .wb_valid (wb_valid),
         .wb_tag   (wb_tag),
         .wb_data  (wb_data),
         .rd_data  (rd_data[k*DATA_W +: DATA_W]),
         .rd_ready (rd_ready[k])
      );
   end

endmodule : phys_regfile

// File: tb/tb_phys_regfile.sv
// Scoreboard bench for phys_regfile: the driver pushes expected read results
// into a queue; the monitor pops and compares them at each falling edge.
module tb_phys_regfile;
   import prf_pkg::*;

   localparam int unsigned NRD = 4;
   localparam int unsigned NWB = 2;
   localparam int unsigned NAL = 2;
   localparam int unsigned TW  = TAG_W;
   localparam int unsigned DW  = DATA_W;
   localparam int unsigned NP  = NUM_PREGS;

   logic clk = 1'b0;
   logic reset;

   ptag_t           rt [NRD];
   ptag_t           wt [NWB];
   pdata_t          wd [NWB];
   ptag_t           at [NAL];
   logic [NWB-1:0]  wv;
   logic [NAL-1:0]  av;

   logic [NRD*TW-1:0] rd_tag;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_ready;
   logic [NWB*TW-1:0] wb_tag;
   logic [NWB*DW-1:0] wb_data;
   logic [NAL*TW-1:0] alloc_tag;
   logic              wb_conflict;

   for (genvar k = 0; k < NRD; k++) begin : g_rdp
      assign rd_tag[k*TW +: TW] = rt[k];
   end
   for (genvar i = 0; i < NWB; i++) begin : g_wbp
      assign wb_tag[i*TW +: TW]  = wt[i];
      assign wb_data[i*DW +: DW] = wd[i];
   end
   for (genvar j = 0; j < NAL; j++) begin : g_alp
      assign alloc_tag[j*TW +: TW] = at[j];
   end

   phys_regfile #(
      .NUM_PREGS (NP),
      .DATA_W    (DW),
      .NUM_RD    (NRD),
      .NUM_WB    (NWB),
      .NUM_ALLOC (NAL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_tag      (rd_tag),
      .rd_data     (rd_data),
      .rd_ready    (rd_ready),
      .wb_valid    (wv),
      .wb_tag      (wb_tag),
      .wb_data     (wb_data),
      .alloc_valid (av),
      .alloc_tag   (alloc_tag),
      .wb_conflict (wb_conflict)
   );

   always #5 clk = ~clk;

   // port < NRD: read port check; port == NRD: wb_conflict check (r only)
   typedef struct {
      int unsigned port;
      pdata_t      d;
      logic        r;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference state for the random sweep.
   pdata_t m_data  [NP];
   logic   m_ready [NP];
   logic   m_cf;

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_data[p]  = '0;
         m_ready[p] = 1'b1;
      end
      m_cf = 1'b0;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_reset();
      end else begin
         for (int i = 0; i < NWB; i++) begin
            if (wv[i] && wt[i] != '0) begin
               m_data[wt[i]]  = wd[i];
               m_ready[wt[i]] = 1'b1;
            end
         end
         for (int j = 0; j < NAL; j++) begin
            if (av[j] && at[j] != '0) m_ready[at[j]] = 1'b0;
         end
         if (wv[0] && wv[1] && wt[0] == wt[1] && wt[0] != '0) m_cf = 1'b1;
      end
   end

   function automatic void model_read(input ptag_t t, output pdata_t d, output logic r);
      d = m_data[t];
      r = m_ready[t];
      for (int i = 0; i < NWB; i++) begin
         if (wv[i] && wt[i] == t) begin
            d = wd[i];
            r = 1'b1;
         end
      end
      if (t == '0) begin
         d = '0;
         r = 1'b1;
      end
   endfunction

   // Monitor: compare every queued expectation against the live outputs.
   always @(negedge clk) begin
      exp_t   e;
      pdata_t ad;
      logic   ar;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.port < NRD) begin
            ad = rd_data[e.port*DW +: DW];
            ar = rd_ready[e.port];
         end else begin
            ad = '0;
            ar = wb_conflict;
         end
         n_chk++;
         if (ad !== e.d || ar !== e.r) begin
            n_fail++;
            $display("FAIL %s: got data=%h ready=%b, expected data=%h ready=%b",
                     e.nm, ad, ar, e.d, e.r);
         end
      end
   end

   task automatic clear_strobes();
      wv = '0;
      av = '0;
      for (int i = 0; i < NWB; i++) begin
         wt[i] = '0;
         wd[i] = '0;
      end
      for (int j = 0; j < NAL; j++) at[j] = '0;
   endtask

   task automatic begin_cycle();
      @(posedge clk);
      #1;
      clear_strobes();
   endtask

   task automatic expect_rd(input int unsigned k, input ptag_t t, input pdata_t d,
                            input logic r, input string nm);
      exp_t e;
      rt[k] = t;
      e = '{port: k, d: d, r: r, nm: nm};
      sb.push_back(e);
   endtask

   task automatic expect_cf(input logic r, input string nm);
      exp_t e;
      e = '{port: NRD, d: '0, r: r, nm: nm};
      sb.push_back(e);
   endtask

   task automatic wb(input int unsigned i, input ptag_t t, input pdata_t d);
      wv[i] = 1'b1;
      wt[i] = t;
      wd[i] = d;
   endtask

   task automatic alloc(input int unsigned j, input ptag_t t);
      av[j] = 1'b1;
      at[j] = t;
   endtask

   initial begin
      pdata_t ed;
      logic   er;
      reset = 1'b1;
      model_reset();
      clear_strobes();
      for (int k = 0; k < NRD; k++) rt[k] = '0;

      // Reset state
      begin_cycle();
      expect_rd(0, 7'd5, 32'h0, 1'b1, "reset_p5");
      expect_rd(1, 7'd0, 32'h0, 1'b1, "reset_p0");
      expect_rd(2, 7'd127, 32'h0, 1'b1, "reset_p127");
      expect_cf(1'b0, "reset_conflict");

      // Alloc p40/p41; alloc is not bypassed
      begin_cycle();
      reset = 1'b0;
      alloc(0, 7'd40);
      alloc(1, 7'd41);
      expect_rd(0, 7'd40, 32'h0, 1'b1, "alloc_nobypass");

      begin_cycle();
      expect_rd(0, 7'd40, 32'h0, 1'b0, "alloc_p40_ready0");
      expect_rd(1, 7'd41, 32'h0, 1'b0, "alloc_p41_ready0");

      // Writeback bypass then storage
      begin_cycle();
      wb(0, 7'd40, 32'hDEADBEEF);
      expect_rd(0, 7'd40, 32'hDEADBEEF, 1'b1, "wb_bypass_p40");
      expect_rd(1, 7'd41, 32'h0, 1'b0, "wb_other_p41");
      expect_rd(2, 7'd40, 32'hDEADBEEF, 1'b1, "wb_bypass_dup");

      begin_cycle();
      expect_rd(0, 7'd40, 32'hDEADBEEF, 1'b1, "wb_stored_p40");

      // p0 protection
      begin_cycle();
      wb(0, 7'd0, 32'h1234);
      wb(1, 7'd0, 32'h5678);
      alloc(0, 7'd0);
      expect_rd(0, 7'd0, 32'h0, 1'b1, "p0_bypass_blocked");

      begin_cycle();
      expect_rd(0, 7'd0, 32'h0, 1'b1, "p0_stored");
      expect_cf(1'b0, "p0_no_conflict");

      // Same-tag writebacks: highest port wins, conflict next cycle
      begin_cycle();
      wb(0, 7'd7, 32'h11);
      wb(1, 7'd7, 32'h22);
      expect_rd(0, 7'd7, 32'h22, 1'b1, "same_tag_bypass");
      expect_cf(1'b0, "conflict_not_yet");

      begin_cycle();
      expect_rd(0, 7'd7, 32'h22, 1'b1, "same_tag_stored");
      expect_cf(1'b1, "conflict_set");

      // Alloc vs writeback on the same tag
      begin_cycle();
      alloc(1, 7'd9);
      wb(0, 7'd9, 32'h55);
      expect_rd(0, 7'd9, 32'h55, 1'b1, "alloc_wb_bypass");
      expect_cf(1'b1, "conflict_sticky");

      begin_cycle();
      expect_rd(0, 7'd9, 32'h55, 1'b0, "alloc_wins_ready");

      // More writes, then reset between edges
      begin_cycle();
      wb(0, 7'd20, 32'hA1);
      wb(1, 7'd21, 32'hB2);
      expect_rd(0, 7'd20, 32'hA1, 1'b1, "wb_p20_bypass");
      expect_rd(1, 7'd21, 32'hB2, 1'b1, "wb_p21_bypass");

      begin_cycle();
      expect_rd(0, 7'd20, 32'hA1, 1'b1, "wb_p20_stored");
      expect_rd(1, 7'd21, 32'hB2, 1'b1, "wb_p21_stored");

      begin_cycle();
      reset = 1'b1;
      expect_rd(0, 7'd20, 32'h0, 1'b1, "midreset_p20");
      expect_rd(1, 7'd21, 32'h0, 1'b1, "midreset_p21");
      expect_rd(2, 7'd7, 32'h0, 1'b1, "midreset_p7");
      expect_rd(3, 7'd9, 32'h0, 1'b1, "midreset_p9");
      expect_cf(1'b0, "midreset_conflict");

      begin_cycle();
      reset = 1'b0;

      // Random sweep on a small tag window to force bypass/alloc/conflict hits
      for (int c = 0; c < 10000; c++) begin
         begin_cycle();
         for (int i = 0; i < NWB; i++) begin
            if ($urandom_range(0, 1) == 1) wb(i, ptag_t'($urandom_range(0, 15)), pdata_t'($urandom));
         end
         for (int j = 0; j < NAL; j++) begin
            if ($urandom_range(0, 3) == 0) alloc(j, ptag_t'($urandom_range(0, 15)));
         end
         for (int k = 0; k < NRD; k++) begin
            rt[k] = ptag_t'($urandom_range(0, 15));
            model_read(rt[k], ed, er);
            expect_rd(k, rt[k], ed, er, $sformatf("rnd_rd%0d", k));
         end
         expect_cf(m_cf, "rnd_conflict");
      end

      begin_cycle();
      @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_phys_regfile
